dispatch_ctrl: RTL and testbench
================================

// Module: dispatch_ctrl
// PURPOSE
//  Sequences dispatch of decoded uops into the OoO backend; sits between decode and ALU/LSU/BRU RS + ROB.
//  Per uop: allocates a ROB index, routes by uop_class, gates on per-RS credits and ROB occupancy.
//  Illegal/MISC uops trap precisely: ROB drained, then one trap pulse. Redirect flushes all state.
// PARAMETERS
//  ROB_DEPTH   16  ROB entries; power of 2; RIW = $clog2(ROB_DEPTH)
//  ALU_CREDITS  8  ALU reservation-station slots
//  LSU_CREDITS  8  LSU reservation-station slots
//  BRU_CREDITS  4  BRU reservation-station slots
// PORTS
//  clk             in   1    clock
//  rst_n           in   1    asynchronous active-low reset
//  redirect_valid  in   1    backend flush; all RS/ROB contents discarded this cycle
//  decode_valid    in   1    decoded uop available
//  decode_ready    out  1    dispatch accepts uop (combinational)
//  decoded_bundle_fields in decoded_bundle_t  uop from decode
//  disp_valid      out  1    registered dispatch pulse
//  disp_target     out  disp_target_t  DT_ALU / DT_LSU / DT_BRU
//  disp_bundle     out  decoded_bundle_t  registered copy of accepted uop
//  disp_rob_idx    out  RIW  ROB index allocated to disp_bundle
//  alu_credit_ret  in   1    ALU RS freed one slot (issue)
//  lsu_credit_ret  in   1    LSU RS freed one slot
//  bru_credit_ret  in   1    BRU RS freed one slot
//  commit_valid    in   1    ROB retired head entry
//  trap_valid      out  1    one-cycle illegal-instruction trap
//  trap_pc         out  32   pc of trapping uop; held until next trap
// BEHAVIOUR
//  Reset: state=RUN; rob_head=rob_tail=rob_count=0; credits=max; disp_valid=0; disp_target=DT_ALU;
//    disp_bundle='0; disp_rob_idx=0; trap_valid=0; trap_pc=0.
//  Routing: UOP_ALU->DT_ALU; UOP_LOAD/UOP_STORE->DT_LSU; UOP_BRANCH/UOP_JUMP->DT_BRU;
//    UOP_MISC or op==OP_ILLEGAL -> trap path (no credit, no ROB entry).
//  Normal accept (RUN): decode_ready = !redirect_valid && rob_count<ROB_DEPTH && credit[target]>0;
//    trap-path uop in RUN: decode_ready = !redirect_valid (no ROB/credit check).
//  Fire = decode_valid && decode_ready. Normal fire: next cycle disp_valid=1, disp_bundle/target,
//    disp_rob_idx=rob_tail; rob_tail+=1 (wraps mod ROB_DEPTH); rob_count+=1; credit[target]-=1.
//    Latency 1 cycle; no downstream backpressure (credits guarantee space). disp_valid=0 otherwise.
//  commit_valid: rob_head+=1 (wrap), rob_count-=1; commit with rob_count==0 is ignored (assert in sim).
//  Same-cycle alloc+commit: count unchanged. Same-cycle dispatch+credit_ret on one RS: credit unchanged.
//  credit_ret with credit==max ignored (assert in sim); credits saturate at max, never below 0.
//  FSM:
//    RUN   : trap-path fire -> latch trap_pc=bundle.pc, go DRAIN.
//    DRAIN : decode_ready=0; rob_count==0 (after this cycle's commit) -> TRAP.
//    TRAP  : trap_valid=1 for exactly one cycle; decode_ready=0 -> HALT.
//    HALT  : decode_ready=0; waits for redirect_valid.
//  redirect_valid (any state, highest priority): next state RUN; rob_head=rob_tail=0; rob_count=0;
//    all credits=max; disp_valid=0 next cycle; trap_valid forced 0; no fire that cycle;
//    commit/credit_ret inputs that cycle ignored. trap_pc retained.
//  Reset mid-operation: immediate return to reset values, including mid-DRAIN/TRAP.
//  rob_count width RIW+1 so full (==ROB_DEPTH) is distinguishable from empty.
// STRUCTURE
//  Shared package (defines.svh): disp_target_t {DT_ALU,DT_LSU,DT_BRU}, disp_state_t
//    {DS_RUN,DS_DRAIN,DS_TRAP,DS_HALT}; reuses decoded_bundle_t, uop_class, OP_ILLEGAL.
//  Sub-module credit_counter #(MAX): inc/dec/flush, count out, nonzero flag; instantiated 3x.
//  Top holds FSM, ROB head/tail/count, output register, routing decode.
// TESTING
//  1 Reset then 3 ALU uops back-to-back -> disp_valid 3 cycles, rob_idx 0,1,2, ALU credits 8->5.
//  2 5 BRU uops, no credit_ret -> 4 dispatch, 5th stalls decode_ready=0; one bru_credit_ret -> 5th fires.
//  3 ROB_DEPTH=16: 16 LSU/ALU mix with returns, no commit -> 17th stalls; commit+dispatch same cycle
//    -> count stays 16, rob_idx wraps 15->0.
//  4 Illegal uop pc=0x100 with rob_count=2 -> DRAIN; 2 commits -> trap_valid 1 cycle, trap_pc=0x100;
//    HALT keeps decode_ready=0 until redirect_valid.
//  5 redirect_valid same cycle as decode_valid+commit+alu_credit_ret -> no fire, count=0, credits=max,
//    state RUN, next uop gets rob_idx 0.
//  6 rst_n low during TRAP -> trap_valid=0, all outputs at reset values next edge.

Source files
------------

// File: rtl/dispatch_ctrl_pkg.sv
// Shared types for the dispatch stage: uop bundle, routing targets, FSM state codes.
package dispatch_ctrl_pkg;

  // Functional class assigned by decode
  typedef enum logic [2:0] {
    UOP_ALU    = 3'd0,
    UOP_LOAD   = 3'd1,
    UOP_STORE  = 3'd2,
    UOP_BRANCH = 3'd3,
    UOP_JUMP   = 3'd4,
    UOP_MISC   = 3'd5
  } uop_class_t;

  // Opcode value decode uses to flag an undecodable instruction
  localparam logic [7:0] OP_ILLEGAL = 8'hFF;

  typedef struct packed {
    logic [31:0] pc;
    uop_class_t  uop_class;
    logic [7:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
  } decoded_bundle_t;

  typedef enum logic [1:0] {
    DT_ALU = 2'd0,
    DT_LSU = 2'd1,
    DT_BRU = 2'd2
  } disp_target_t;

  // FSM state codes kept as plain constants so older tools/scripts can match them
  typedef logic [1:0] disp_state_t;
  localparam disp_state_t DS_RUN   = 2'd0;
  localparam disp_state_t DS_DRAIN = 2'd1;
  localparam disp_state_t DS_TRAP  = 2'd2;
  localparam disp_state_t DS_HALT  = 2'd3;

  // Uops that never enter the backend: they take the precise-trap path
  function automatic logic is_trap_uop(input decoded_bundle_t b);
    return (b.uop_class == UOP_MISC) || (b.op == OP_ILLEGAL);
  endfunction

  // Reservation station a normal uop is sent to
  function automatic disp_target_t route_target(input uop_class_t c);
    disp_target_t t;
    case (c)
      UOP_LOAD, UOP_STORE:  t = DT_LSU;
      UOP_BRANCH, UOP_JUMP: t = DT_BRU;
      default:              t = DT_ALU;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/dispatch_ctrl_credit_counter.sv
// Saturating credit counter for one reservation station.
// Starts full; a dispatch consumes a slot, an issue returns one, a flush refills.
module credit_counter #(
  parameter int MAX = 8,
  parameter int CW  = $clog2(MAX + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_flush,
  input  logic          i_inc,
  input  logic          i_dec,
  output logic [CW-1:0] o_count,
  output logic          o_nonzero
);

  localparam logic [CW-1:0] C_MAX = CW'(MAX);

  logic [CW-1:0] r_count;

  // Credit update: flush wins, simultaneous inc/dec cancel, ends saturate
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= C_MAX;
    end else if (i_flush) begin
      r_count <= C_MAX;
    end else if (i_inc && !i_dec) begin
      if (r_count != C_MAX) r_count <= r_count + 1'b1;
    end else if (i_dec && !i_inc) begin
      if (r_count != '0) r_count <= r_count - 1'b1;
    end
  end

  assign o_count   = r_count;
  assign o_nonzero = (r_count != '0);

  // A return with every slot already free means the RS and dispatch disagree
  a_no_overflow_ret: assert property (@(posedge clk) disable iff (!rst_n)
    !(i_inc && !i_dec && !i_flush && r_count == C_MAX));

endmodule

// File: rtl/dispatch_ctrl.sv
// Dispatch controller: allocates ROB slots, routes uops to ALU/LSU/BRU RS,
// throttles on RS credits and ROB occupancy, and turns illegal/MISC uops
// into a precise trap once all older uops have retired.
module dispatch_ctrl
  import dispatch_ctrl_pkg::*;
#(
  parameter int ROB_DEPTH   = 16,
  parameter int ALU_CREDITS = 8,
  parameter int LSU_CREDITS = 8,
  parameter int BRU_CREDITS = 4,
  parameter int RIW         = $clog2(ROB_DEPTH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            redirect_valid,
  input  logic            decode_valid,
  output logic            decode_ready,
  input  decoded_bundle_t decoded_bundle_fields,
  output logic            disp_valid,
  output disp_target_t    disp_target,
  output decoded_bundle_t disp_bundle,
  output logic [RIW-1:0]  disp_rob_idx,
  input  logic            alu_credit_ret,
  input  logic            lsu_credit_ret,
  input  logic            bru_credit_ret,
  input  logic            commit_valid,
  output logic            trap_valid,
  output logic [31:0]     trap_pc
);

  localparam logic [RIW:0] ROB_FULL = (RIW + 1)'(ROB_DEPTH);
  localparam int ACW = $clog2(ALU_CREDITS + 1);
  localparam int LCW = $clog2(LSU_CREDITS + 1);
  localparam int BCW = $clog2(BRU_CREDITS + 1);

  disp_state_t     r_state, w_state_next;
  logic [RIW-1:0]  r_rob_head, r_rob_tail;
  logic [RIW:0]    r_rob_count, w_rob_count_next;
  logic            r_disp_valid;
  disp_target_t    r_disp_target;
  decoded_bundle_t r_disp_bundle;
  logic [RIW-1:0]  r_disp_rob_idx;
  logic [31:0]     r_trap_pc;

  logic            w_is_trap;
  disp_target_t    w_target;
  logic            w_credit_ok;
  logic            w_rob_space;
  logic            w_fire, w_alloc, w_trap_fire, w_commit;
  logic            w_alu_nz, w_lsu_nz, w_bru_nz;
  logic [ACW-1:0]  w_alu_count;
  logic [LCW-1:0]  w_lsu_count;
  logic [BCW-1:0]  w_bru_count;

  // ---------------- routing and accept decision ----------------
  assign w_is_trap   = is_trap_uop(decoded_bundle_fields);
  assign w_target    = route_target(decoded_bundle_fields.uop_class);
  assign w_rob_space = (r_rob_count < ROB_FULL);

  // Credit availability for the RS this uop would go to
  always_comb begin
    w_credit_ok = 1'b0;
    case (w_target)
      DT_LSU:  w_credit_ok = w_lsu_nz;
      DT_BRU:  w_credit_ok = w_bru_nz;
      default: w_credit_ok = w_alu_nz;
    endcase
  end

  // Trap-path uops only need the pipe to be running; normal uops need ROB space and a credit
  assign decode_ready = (r_state == DS_RUN) && !redirect_valid &&
                        (w_is_trap || (w_rob_space && w_credit_ok));

  assign w_fire      = decode_valid && decode_ready;
  assign w_alloc     = w_fire && !w_is_trap;
  assign w_trap_fire = w_fire && w_is_trap;
  // A retire against an empty ROB is dropped; a flush swallows it too
  assign w_commit    = commit_valid && !redirect_valid && (r_rob_count != '0);

  // ---------------- reservation-station credits ----------------
  credit_counter #(.MAX(ALU_CREDITS)) u_alu_credits (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_flush   (redirect_valid),
    .i_inc     (alu_credit_ret && !redirect_valid),
    .i_dec     (w_alloc && (w_target == DT_ALU)),
    .o_count   (w_alu_count),
    .o_nonzero (w_alu_nz)
  );

  credit_counter #(.MAX(LSU_CREDITS)) u_lsu_credits (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_flush   (redirect_valid),
    .i_inc     (lsu_credit_ret && !redirect_valid),
    .i_dec     (w_alloc && (w_target == DT_LSU)),
    .o_count   (w_lsu_count),
    .o_nonzero (w_lsu_nz)
  );

  credit_counter #(.MAX(BRU_CREDITS)) u_bru_credits (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_flush   (redirect_valid),
    .i_inc     (bru_credit_ret && !redirect_valid),
    .i_dec     (w_alloc && (w_target == DT_BRU)),
    .o_count   (w_bru_count),
    .o_nonzero (w_bru_nz)
  );

  // ---------------- ROB pointer bookkeeping ----------------
  // Next occupancy: alloc and commit in the same cycle cancel
  always_comb begin
    w_rob_count_next = r_rob_count;
    if (redirect_valid) begin
      w_rob_count_next = '0;
    end else begin
      case ({w_alloc, w_commit})
        2'b10:   w_rob_count_next = r_rob_count + 1'b1;
        2'b01:   w_rob_count_next = r_rob_count - 1'b1;
        default: w_rob_count_next = r_rob_count;
      endcase
    end
  end

  // Head/tail advance with natural wrap at ROB_DEPTH; flush empties the ROB
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rob_head  <= '0;
      r_rob_tail  <= '0;
      r_rob_count <= '0;
    end else if (redirect_valid) begin
      r_rob_head  <= '0;
      r_rob_tail  <= '0;
      r_rob_count <= '0;
    end else begin
      if (w_alloc)  r_rob_tail <= r_rob_tail + 1'b1;
      if (w_commit) r_rob_head <= r_rob_head + 1'b1;
      r_rob_count <= w_rob_count_next;
    end
  end

  // ---------------- trap sequencing FSM ----------------
  // RUN until a trap uop is taken, wait for older uops to retire, pulse, then halt
  always_comb begin
    w_state_next = r_state;
    if (redirect_valid) begin
      w_state_next = DS_RUN;
    end else begin
      case (r_state)
        DS_RUN:   if (w_trap_fire) w_state_next = DS_DRAIN;
        DS_DRAIN: if (w_rob_count_next == '0) w_state_next = DS_TRAP;
        DS_TRAP:  w_state_next = DS_HALT;
        default:  w_state_next = DS_HALT;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= DS_RUN;
    else        r_state <= w_state_next;
  end

  // Capture the pc of the trapping uop; it survives flushes for the handler to read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           r_trap_pc <= '0;
    else if (w_trap_fire) r_trap_pc <= decoded_bundle_fields.pc;
  end

  assign trap_valid = (r_state == DS_TRAP) && !redirect_valid;
  assign trap_pc    = r_trap_pc;

  // ---------------- dispatch output register ----------------
  // One-cycle dispatch pulse; payload holds its last value between pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_disp_valid   <= 1'b0;
      r_disp_target  <= DT_ALU;
      r_disp_bundle  <= '0;
      r_disp_rob_idx <= '0;
    end else begin
      r_disp_valid <= w_alloc;
      if (w_alloc) begin
        r_disp_target  <= w_target;
        r_disp_bundle  <= decoded_bundle_fields;
        r_disp_rob_idx <= r_rob_tail;
      end
    end
  end

  assign disp_valid   = r_disp_valid;
  assign disp_target  = r_disp_target;
  assign disp_bundle  = r_disp_bundle;
  assign disp_rob_idx = r_disp_rob_idx;

  // ---------------- sanity properties ----------------
  a_commit_nonempty: assert property (@(posedge clk) disable iff (!rst_n)
    !(commit_valid && !redirect_valid && r_rob_count == '0));

  a_count_bound: assert property (@(posedge clk) disable iff (!rst_n)
    (r_rob_count <= ROB_FULL) &&
    (w_alu_count <= ACW'(ALU_CREDITS)) &&
    (w_lsu_count <= LCW'(LSU_CREDITS)) &&
    (w_bru_count <= BCW'(BRU_CREDITS)));

  a_ptr_consistent: assert property (@(posedge clk) disable iff (!rst_n)
    (r_rob_count == ROB_FULL) || (RIW'(r_rob_tail - r_rob_head) == r_rob_count[RIW-1:0]));

endmodule

// File: tb/tb_dispatch_ctrl.sv
// Scoreboard bench for dispatch_ctrl: expected dispatches are queued when a
// uop is offered and popped when disp_valid appears.
module tb_dispatch_ctrl;
  import dispatch_ctrl_pkg::*;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            redirect_valid;
  logic            decode_valid;
  logic            decode_ready;
  decoded_bundle_t decoded_bundle_fields;
  logic            disp_valid;
  disp_target_t    disp_target;
  decoded_bundle_t disp_bundle;
  logic [3:0]      disp_rob_idx;
  logic            alu_credit_ret, lsu_credit_ret, bru_credit_ret;
  logic            commit_valid;
  logic            trap_valid;
  logic [31:0]     trap_pc;

  always #5 clk = ~clk;

  dispatch_ctrl dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .redirect_valid        (redirect_valid),
    .decode_valid          (decode_valid),
    .decode_ready          (decode_ready),
    .decoded_bundle_fields (decoded_bundle_fields),
    .disp_valid            (disp_valid),
    .disp_target           (disp_target),
    .disp_bundle           (disp_bundle),
    .disp_rob_idx          (disp_rob_idx),
    .alu_credit_ret        (alu_credit_ret),
    .lsu_credit_ret        (lsu_credit_ret),
    .bru_credit_ret        (bru_credit_ret),
    .commit_valid          (commit_valid),
    .trap_valid            (trap_valid),
    .trap_pc               (trap_pc)
  );

  typedef struct {
    logic [3:0]      idx;
    disp_target_t    tgt;
    decoded_bundle_t b;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   tb_idx   = 0;
  int   pc_seq   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic disp_target_t exp_tgt(input uop_class_t c);
    if (c == UOP_LOAD || c == UOP_STORE)  return DT_LSU;
    if (c == UOP_BRANCH || c == UOP_JUMP) return DT_BRU;
    return DT_ALU;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one uop for one cycle; queue the expected dispatch when it should be taken
  task automatic drive_uop(input uop_class_t c, input logic [7:0] op, input logic [31:0] pc,
                           input bit exp_rdy, input string tag);
    decoded_bundle_t b;
    b           = '0;
    b.pc        = pc;
    b.uop_class = c;
    b.op        = op;
    b.rd        = 5'(tb_idx);
    b.rs1       = 5'(pc_seq);
    decode_valid          = 1'b1;
    decoded_bundle_fields = b;
    #1;
    check(tag, 64'(decode_ready), 64'(exp_rdy));
    if (exp_rdy && c != UOP_MISC && op != OP_ILLEGAL) begin
      exp_q.push_back('{idx: 4'(tb_idx), tgt: exp_tgt(c), b: b});
      tb_idx++;
    end
    @(posedge clk);
    #1;
    decode_valid = 1'b0;
  endtask

  function automatic logic [31:0] next_pc();
    pc_seq++;
    return 32'h1000 + 32'(pc_seq * 4);
  endfunction

  // Scoreboard: every dispatch pulse must match the oldest queued expectation
  always @(negedge clk) begin
    if (rst_n && disp_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_disp", 64'(1), 64'(0));
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        $display("disp idx=%0d tgt=%0d pc=0x%08h", disp_rob_idx, disp_target, disp_bundle.pc);
        check("disp_rob_idx", 64'(disp_rob_idx), 64'(e.idx));
        check("disp_target", 64'(disp_target), 64'(e.tgt));
        check("disp_bundle", 64'(disp_bundle), 64'(e.b));
      end
    end
  end

  initial begin
    rst_n = 1'b0; redirect_valid = 1'b0; decode_valid = 1'b0; decoded_bundle_fields = '0;
    alu_credit_ret = 1'b0; lsu_credit_ret = 1'b0; bru_credit_ret = 1'b0; commit_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_disp_valid", 64'(disp_valid), 64'(0));
    check("rst_trap_valid", 64'(trap_valid), 64'(0));
    check("rst_trap_pc", 64'(trap_pc), 64'(0));
    check("rst_rob_idx", 64'(disp_rob_idx), 64'(0));
    check("rst_bundle", 64'(disp_bundle), 64'(0));
    check("rst_target", 64'(disp_target), 64'(DT_ALU));
    rst_n = 1'b1;
    tick();
    check("rst_ready", 64'(decode_ready), 64'(1));

    // 1: back-to-back ALU, then exhaust the remaining 5 ALU credits
    for (int k = 0; k < 8; k++) drive_uop(UOP_ALU, 8'h01, next_pc(), 1'b1, "t1_alu_ready");
    drive_uop(UOP_ALU, 8'h01, next_pc(), 1'b0, "t1_alu_credit_empty");
    alu_credit_ret = 1'b1; commit_valid = 1'b1;
    repeat (8) tick();
    alu_credit_ret = 1'b0; commit_valid = 1'b0;

    // 2: BRU has 4 credits; the 5th waits for a return
    for (int k = 0; k < 4; k++)
      drive_uop((k % 2) ? UOP_JUMP : UOP_BRANCH, 8'h02, next_pc(), 1'b1, "t2_bru_ready");
    drive_uop(UOP_BRANCH, 8'h02, next_pc(), 1'b0, "t2_bru_stall");
    bru_credit_ret = 1'b1;
    tick();
    bru_credit_ret = 1'b0;
    drive_uop(UOP_BRANCH, 8'h02, next_pc(), 1'b1, "t2_bru_after_ret");
    for (int k = 0; k < 5; k++) begin
      commit_valid = 1'b1; bru_credit_ret = (k < 4);
      tick();
    end
    commit_valid = 1'b0; bru_credit_ret = 1'b0;

    // 3: fill the ROB (index wraps), then check same-cycle alloc+commit holds occupancy
    for (int k = 0; k < 16; k++) begin
      if (k % 2) drive_uop(UOP_ALU, 8'h03, next_pc(), 1'b1, "t3_fill");
      else       drive_uop((k % 4) ? UOP_STORE : UOP_LOAD, 8'h04, next_pc(), 1'b1, "t3_fill");
    end
    alu_credit_ret = 1'b1; lsu_credit_ret = 1'b1;
    repeat (8) tick();
    alu_credit_ret = 1'b0; lsu_credit_ret = 1'b0;
    drive_uop(UOP_ALU, 8'h03, next_pc(), 1'b0, "t3_rob_full");
    commit_valid = 1'b1;
    tick();
    drive_uop(UOP_ALU, 8'h03, next_pc(), 1'b1, "t3_alloc_commit");
    commit_valid = 1'b0;
    drive_uop(UOP_ALU, 8'h03, next_pc(), 1'b1, "t3_refill");
    drive_uop(UOP_ALU, 8'h03, next_pc(), 1'b0, "t3_count_held");
    for (int k = 0; k < 16; k++) begin
      commit_valid = 1'b1; alu_credit_ret = (k < 2);
      tick();
    end
    commit_valid = 1'b0; alu_credit_ret = 1'b0;

    // 4: illegal uop with two older uops in flight
    drive_uop(UOP_ALU, 8'h05, next_pc(), 1'b1, "t4_older");
    drive_uop(UOP_ALU, 8'h05, next_pc(), 1'b1, "t4_older");
    drive_uop(UOP_ALU, OP_ILLEGAL, 32'h100, 1'b1, "t4_trap_accept");
    decode_valid = 1'b1; decoded_bundle_fields.pc = 32'h2000; decoded_bundle_fields.op = 8'h05;
    commit_valid = 1'b1;
    #1;
    check("t4_drain_ready", 64'(decode_ready), 64'(0));
    check("t4_drain_no_trap", 64'(trap_valid), 64'(0));
    tick();
    check("t4_drain_no_trap2", 64'(trap_valid), 64'(0));
    tick();
    commit_valid = 1'b0;
    #1;
    check("t4_trap_pulse", 64'(trap_valid), 64'(1));
    check("t4_trap_pc", 64'(trap_pc), 64'(32'h100));
    check("t4_trap_ready", 64'(decode_ready), 64'(0));
    tick();
    check("t4_trap_one_cycle", 64'(trap_valid), 64'(0));
    repeat (3) tick();
    check("t4_halt_ready", 64'(decode_ready), 64'(0));
    redirect_valid = 1'b1;
    #1;
    check("t4_redirect_ready", 64'(decode_ready), 64'(0));
    tick();
    redirect_valid = 1'b0; decode_valid = 1'b0;
    tb_idx = 0;
    check("t4_trap_pc_kept", 64'(trap_pc), 64'(32'h100));

    // 5: redirect together with decode, commit and credit return
    drive_uop(UOP_ALU, 8'h06, next_pc(), 1'b1, "t5_pre");
    drive_uop(UOP_ALU, 8'h06, next_pc(), 1'b1, "t5_pre");
    decode_valid = 1'b1; decoded_bundle_fields.op = 8'h06;
    commit_valid = 1'b1; alu_credit_ret = 1'b1; redirect_valid = 1'b1;
    #1;
    check("t5_redirect_no_fire", 64'(decode_ready), 64'(0));
    tick();
    decode_valid = 1'b0; commit_valid = 1'b0; alu_credit_ret = 1'b0; redirect_valid = 1'b0;
    tb_idx = 0;
    for (int k = 0; k < 8; k++) drive_uop(UOP_ALU, 8'h06, next_pc(), 1'b1, "t5_after_redirect");
    drive_uop(UOP_ALU, 8'h06, next_pc(), 1'b0, "t5_credits_max");

    // 6: reset asserted while the trap pulse is up
    drive_uop(UOP_MISC, 8'h07, 32'h200, 1'b1, "t6_trap_accept");
    commit_valid = 1'b1;
    repeat (8) tick();
    commit_valid = 1'b0;
    #1;
    check("t6_in_trap", 64'(trap_valid), 64'(1));
    check("t6_trap_pc", 64'(trap_pc), 64'(32'h200));
    rst_n = 1'b0;
    #1;
    check("t6_rst_trap_valid", 64'(trap_valid), 64'(0));
    check("t6_rst_trap_pc", 64'(trap_pc), 64'(0));
    check("t6_rst_disp_valid", 64'(disp_valid), 64'(0));
    check("t6_rst_rob_idx", 64'(disp_rob_idx), 64'(0));
    check("t6_rst_bundle", 64'(disp_bundle), 64'(0));
    tick();
    check("t6_rst_hold_trap", 64'(trap_valid), 64'(0));
    rst_n = 1'b1;
    tb_idx = 0;
    tick();
    drive_uop(UOP_LOAD, 8'h08, next_pc(), 1'b1, "t6_after_reset");
    repeat (3) tick();
    check("sb_empty", 64'(exp_q.size()), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
